// File: rtl/trade_pkg.sv
// Shared types and widths for the trade execution path.
// Defines the order record, order sides and the ledger action codes.
package trade_pkg;

    localparam int PRICE_W = 14;
    localparam int QTY_W   = 8;
    localparam int MONEY_W = 32;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef struct packed {
        logic               side;
        logic [1:0]         stock_id;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } order_t;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_BUY,
        ACT_SELL,
        ACT_DROP
    } action_t;

endpackage

// File: rtl/order_fifo.sv
// Synchronous order queue; full/empty come from the registered count.
// Ports: clk, rst (sync active-low), push/push_data, pop, head, full, empty.
module order_fifo
    import trade_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  order_t push_data,
    input  logic   pop,
    output order_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    order_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty queue presents an all-zero record.
    assign head = empty ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trade_executor.sv
// Turns strategy buy/sell decisions into ledger updates and queued orders.
// Ports: decision inputs, order valid/ready output, ledger and drop counters.
module trade_executor
    import trade_pkg::*;
#(
    parameter int LOT_SIZE   = 10,
    parameter int MAX_LOTS   = 3,
    parameter int COOLDOWN   = 4,
    parameter int CASH_INIT  = 200000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        buy_signal,
    input  logic        sell_signal,
    input  logic [1:0]  stock_id,
    input  logic [13:0] current_price,
    input  logic        order_ready,
    output logic        order_valid,
    output logic        order_side,
    output logic [1:0]  order_stock_id,
    output logic [13:0] order_price,
    output logic [7:0]  order_qty,
    output logic [7:0]  position_lots,
    output logic [31:0] cash_balance,
    output logic [31:0] realized_pnl,
    output logic [15:0] drop_count
);

    localparam int CDW = $clog2(COOLDOWN + 1);

    logic [1:0]         lots_q [4];
    logic [MONEY_W-1:0] cost_q [4];
    logic [CDW-1:0]     cd_q   [4];

    logic [1:0]         lots_cur;
    logic [CDW-1:0]     cd_cur;
    logic [MONEY_W-1:0] notional;
    logic [MONEY_W-1:0] proceeds;
    logic               buy_ok;
    logic               sell_ok;
    logic               drop_req;
    action_t            act;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    order_t push_rec;
    order_t head;

    assign lots_cur = lots_q[stock_id];
    assign cd_cur   = cd_q[stock_id];
    assign notional = MONEY_W'(current_price) * MONEY_W'(LOT_SIZE);
    assign proceeds = notional * MONEY_W'(lots_cur);

    assign buy_ok = enable && buy_signal && !sell_signal
                 && (lots_cur < 2'(MAX_LOTS))
                 && (cd_cur == '0)
                 && (cash_balance >= notional)
                 && !full;

    assign sell_ok = enable && sell_signal && !buy_signal
                  && (lots_cur != '0)
                  && (cd_cur == '0)
                  && !full;

    assign drop_req = enable && (buy_signal || sell_signal)
                   && !buy_ok && !sell_ok;

    always_comb begin
        act = ACT_NONE;
        unique case (1'b1)
            buy_ok:   act = ACT_BUY;
            sell_ok:  act = ACT_SELL;
            drop_req: act = ACT_DROP;
            default:  act = ACT_NONE;
        endcase
    end

    always_comb begin
        push_rec          = '0;
        push_rec.stock_id = stock_id;
        push_rec.price    = current_price;
        push              = 1'b0;
        if (act == ACT_BUY) begin
            push          = 1'b1;
            push_rec.side = SIDE_BUY;
            push_rec.qty  = QTY_W'(LOT_SIZE);
        end else if (act == ACT_SELL) begin
            push          = 1'b1;
            push_rec.side = SIDE_SELL;
            push_rec.qty  = QTY_W'(LOT_SIZE) * QTY_W'(lots_cur);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                lots_q[i] <= '0;
                cost_q[i] <= '0;
                cd_q[i]   <= '0;
            end
            cash_balance <= MONEY_W'(CASH_INIT);
            realized_pnl <= '0;
            drop_count   <= '0;
        end else begin
            // A fresh accept reloads the lockout; otherwise count down.
            for (int i = 0; i < 4; i++) begin
                if (push && (stock_id == 2'(i)))
                    cd_q[i] <= CDW'(COOLDOWN);
                else if (cd_q[i] != '0)
                    cd_q[i] <= cd_q[i] - 1'b1;
            end
            unique case (act)
                ACT_BUY: begin
                    lots_q[stock_id] <= lots_cur + 1'b1;
                    cost_q[stock_id] <= cost_q[stock_id] + notional;
                    cash_balance     <= cash_balance - notional;
                end
                ACT_SELL: begin
                    lots_q[stock_id] <= '0;
                    cost_q[stock_id] <= '0;
                    cash_balance     <= cash_balance + proceeds;
                    realized_pnl     <= realized_pnl + proceeds
                                      - cost_q[stock_id];
                end
                ACT_DROP: begin
                    if (drop_count != 16'hFFFF)
                        drop_count <= drop_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        position_lots = '0;
        for (int i = 0; i < 4; i++)
            position_lots[2*i +: 2] = lots_q[i];
    end

    assign order_valid    = !empty;
    assign pop            = order_valid && order_ready;
    assign order_side     = head.side;
    assign order_stock_id = head.stock_id;
    assign order_price    = head.price;
    assign order_qty      = head.qty;

    order_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_rec),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_trade_executor.sv
// Scenario bench for trade_executor with an order scoreboard.
// Expected orders are queued at decision time and checked on handshake.
module tb_trade_executor;
    import trade_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        buy_signal = 1'b0;
    logic        sell_signal = 1'b0;
    logic [1:0]  stock_id = '0;
    logic [13:0] current_price = '0;
    logic        order_ready = 1'b1;
    logic        order_valid;
    logic        order_side;
    logic [1:0]  order_stock_id;
    logic [13:0] order_price;
    logic [7:0]  order_qty;
    logic [7:0]  position_lots;
    logic [31:0] cash_balance;
    logic [31:0] realized_pnl;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;
    order_t sb[$];

    always #5 clk = ~clk;

    trade_executor dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .buy_signal    (buy_signal),
        .sell_signal   (sell_signal),
        .stock_id      (stock_id),
        .current_price (current_price),
        .order_ready   (order_ready),
        .order_valid   (order_valid),
        .order_side    (order_side),
        .order_stock_id(order_stock_id),
        .order_price   (order_price),
        .order_qty     (order_qty),
        .position_lots (position_lots),
        .cash_balance  (cash_balance),
        .realized_pnl  (realized_pnl),
        .drop_count    (drop_count)
    );

    // Scoreboard: every handshake must match the oldest expected order.
    always @(negedge clk) begin
        if (rst && order_valid && order_ready) begin
            order_t got;
            order_t exp;
            got = '{order_side, order_stock_id, order_price, order_qty};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h expected=none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_order got=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic decide(input logic b, input logic s,
                          input logic [1:0] id, input logic [13:0] p,
                          input logic acc);
        buy_signal    = b;
        sell_signal   = s;
        stock_id      = id;
        current_price = p;
        if (acc) begin
            order_t e;
            e.side     = s;
            e.stock_id = id;
            e.price    = p;
            e.qty      = 8'd10;
            sb.push_back(e);
        end
        idle(1);
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(2);
        checks++;
        if ({order_valid, order_side, order_stock_id, order_price,
             order_qty} !== '0) begin
            errors++;
            $display("FAIL reset_order got=%b expected=0", order_valid);
        end
        checks++;
        if (cash_balance !== 32'd200000) begin
            errors++;
            $display("FAIL reset_cash got=%0d expected=200000", cash_balance);
        end
        checks++;
        if ({position_lots, realized_pnl, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_ledger got=%h/%h/%h expected=0",
                     position_lots, realized_pnl, drop_count);
        end
        rst = 1'b1;
    endtask

    task automatic test_cash_limit();
        do_reset();
        order_ready = 1'b1;
        decide(1, 0, 2'd0, 14'd10900, 1);
        checks++;
        if (order_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid got=%b expected=1", order_valid);
        end
        checks++;
        if (cash_balance !== 32'd91000 || position_lots !== 8'h01) begin
            errors++;
            $display("FAIL buy_cash got=%0d lots=%h expected=91000 lots=01",
                     cash_balance, position_lots);
        end
        idle(1);
        checks++;
        if (order_valid !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_valid got=%b expected=0", order_valid);
        end
        idle(4);
        decide(1, 0, 2'd0, 14'd10900, 0);
        checks++;
        if (drop_count !== 16'd1 || cash_balance !== 32'd91000) begin
            errors++;
            $display("FAIL cash_reject got=%0d/%0d expected=1/91000",
                     drop_count, cash_balance);
        end
    endtask

    task automatic test_max_lots_and_sell();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            decide(1, 0, 2'd1, 14'd750, 1);
            idle(4);
        end
        checks++;
        if (cash_balance !== 32'd177500 || position_lots !== 8'h0C) begin
            errors++;
            $display("FAIL three_lots got=%0d lots=%h expected=177500 lots=0c",
                     cash_balance, position_lots);
        end
        decide(1, 0, 2'd1, 14'd750, 0);
        checks++;
        if (drop_count !== 16'd1 || position_lots !== 8'h0C) begin
            errors++;
            $display("FAIL max_lots_drop got=%0d lots=%h expected=1 lots=0c",
                     drop_count, position_lots);
        end
        idle(4);
        sb.push_back('{SIDE_SELL, 2'd1, 14'd800, 8'd30});
        decide(0, 1, 2'd1, 14'd800, 0);
        checks++;
        if (cash_balance !== 32'd201500 || realized_pnl !== 32'd1500 ||
            position_lots !== 8'h00) begin
            errors++;
            $display("FAIL sell_exit got=%0d/%0d/%h expected=201500/1500/00",
                     cash_balance, realized_pnl, position_lots);
        end
        idle(2);
    endtask

    task automatic test_cooldown();
        do_reset();
        decide(1, 0, 2'd2, 14'd1250, 1);
        idle(3);
        decide(1, 0, 2'd2, 14'd1250, 0);
        checks++;
        if (drop_count !== 16'd1 || position_lots !== 8'h10) begin
            errors++;
            $display("FAIL cooldown_drop got=%0d lots=%h expected=1 lots=10",
                     drop_count, position_lots);
        end
        decide(1, 0, 2'd2, 14'd1250, 1);
        checks++;
        if (position_lots !== 8'h20 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL cooldown_accept got=%h drops=%0d expected=20 1",
                     position_lots, drop_count);
        end
        idle(2);
    endtask

    task automatic test_queue_full();
        do_reset();
        order_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            decide(1, 0, 2'(k), 14'd100, 1);
        idle(1);
        decide(1, 0, 2'd0, 14'd100, 0);
        checks++;
        if (drop_count !== 16'd1 || position_lots !== 8'h55) begin
            errors++;
            $display("FAIL full_reject got=%0d lots=%h expected=1 lots=55",
                     drop_count, position_lots);
        end
        checks++;
        if (order_valid !== 1'b1 || order_stock_id !== 2'd0) begin
            errors++;
            $display("FAIL head_hold got=%b/%0d expected=1/0",
                     order_valid, order_stock_id);
        end
        order_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order_valid !== 1'b1 || order_stock_id !== 2'(k)) begin
                errors++;
                $display("FAIL drain_%0d got=%b/%0d expected=1/%0d",
                         k, order_valid, order_stock_id, k);
            end
            idle(1);
        end
        checks++;
        if (order_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got=%b expected=0", order_valid);
        end
    endtask

    task automatic test_conflict_and_enable();
        logic [31:0] cash0;
        logic [7:0]  lots0;
        logic [15:0] drop0;
        cash0 = cash_balance;
        lots0 = position_lots;
        drop0 = drop_count;
        decide(1, 1, 2'd3, 14'd100, 0);
        checks++;
        if (drop_count !== drop0 + 16'd1 || cash_balance !== cash0 ||
            position_lots !== lots0) begin
            errors++;
            $display("FAIL both_high got=%0d/%0d expected=%0d/%0d",
                     drop_count, cash_balance, drop0 + 16'd1, cash0);
        end
        enable = 1'b0;
        decide(1, 0, 2'd3, 14'd100, 0);
        enable = 1'b1;
        checks++;
        if (drop_count !== drop0 + 16'd1 || cash_balance !== cash0 ||
            order_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_low got=%0d/%0d expected=%0d/%0d",
                     drop_count, cash_balance, drop0 + 16'd1, cash0);
        end
    endtask

    task automatic test_reset_mid_drain();
        order_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            decide(1, 0, 2'(k), 14'd500, 1);
        checks++;
        if (order_valid !== 1'b1) begin
            errors++;
            $display("FAIL queued_valid got=%b expected=1", order_valid);
        end
        do_reset();
        order_ready = 1'b1;
        checks++;
        if (order_valid !== 1'b0 || cash_balance !== 32'd200000) begin
            errors++;
            $display("FAIL mid_reset got=%b/%0d expected=0/200000",
                     order_valid, cash_balance);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_cash_limit();
        test_max_lots_and_sell();
        test_cooldown();
        test_queue_full();
        test_conflict_and_enable();
        test_reset_mid_drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trade_executor.md
# trade_executor

Consumes the per-stock buy/sell decisions produced by the strategy blocks (e.g. momentum ignition) and turns them into executed orders. For each accepted decision it updates a per-stock position ledger, cash balance and realized P&L, then queues an order record for the downstream order/reporting interface through a valid/ready handshake. It sits between the strategy layer and the order output port of the trading core.

## Interface
- LOT_SIZE, 10: shares per buy order.
- MAX_LOTS, 3: maximum lots held per stock; must be ≤ 3 (2-bit ledger).
- COOLDOWN, 4: cycles a stock is locked after any accepted order.
- CASH_INIT, 200000: cash balance after reset.
- FIFO_DEPTH, 4: order queue entries.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  decision inputs are sampled only when high.
- buy_signal  input  1  buy decision for stock_id.
- sell_signal  input  1  sell (exit) decision for stock_id.
- stock_id  input  2  stock the decision refers to.
- current_price  input  14  price the decision refers to (unsigned).
- order_ready  input  1  downstream accepts the head order.
- order_valid  output  1  head order present.
- order_side  output  1  0 = buy, 1 = sell.
- order_stock_id  output  2  stock of head order.
- order_price  output  14  execution price.
- order_qty  output  8  shares.
- position_lots  output  8  packed lots held, stock n at bits [2n+1:2n].
- cash_balance  output  32  unsigned cash.
- realized_pnl  output  32  signed cumulative realized P&L.
- drop_count  output  16  rejected decisions, saturating at 16'hFFFF.

## Operation
- Decision inputs must be cycle-aligned; the integration delays stock_id/current_price one cycle to match registered strategy outputs.
- notional = current_price × LOT_SIZE, zero-extended to 32 bits.
- Buy accepted when: enable, buy_signal, !sell_signal, lots[id] < MAX_LOTS, cooldown[id] == 0, cash_balance ≥ notional, queue not full. Effect: lots[id]+1, cash −= notional, cost[id] += notional, push {0, id, price, LOT_SIZE}, cooldown[id] ← COOLDOWN.
- Sell accepted when: enable, sell_signal, !buy_signal, lots[id] > 0, cooldown[id] == 0, queue not full. Exits the whole position: proceeds = price × LOT_SIZE × lots[id]; cash += proceeds; realized_pnl += proceeds − cost[id] (signed, two's-complement wrap); lots[id] ← 0; cost[id] ← 0; push {1, id, price, lots×LOT_SIZE}; cooldown[id] ← COOLDOWN.
- Any other decision with enable high and buy_signal|sell_signal high (including both high) is rejected: drop_count +1 (saturating), no other state change.
- enable low: decisions ignored and not counted; cooldowns still decrement; queue still drains.
- cost[id]: 32-bit per-stock cost basis, internal.

## Timing
- Reset (rst low at an edge): order_valid 0, order fields 0, queue empty, lots 0, cost 0, cooldowns 0, cash_balance CASH_INIT, realized_pnl 0, drop_count 0. Reset mid-drain discards queued orders; order_valid is 0 the cycle after.
- Accept at edge N: ledger outputs updated after N; order_valid high after N if the queue was empty (1-cycle latency).
- Cooldown loaded at accept edge, decrements by 1 at every later edge while nonzero; checked as sampled. Minimum spacing between accepted orders of one stock: COOLDOWN+1 cycles.
- Handshake: head pops on an edge with order_valid && order_ready; fields stable while valid && !ready; one pop per cycle.
- Full is the registered count: a push when full is rejected even if a pop occurs the same cycle. Push into an empty queue with ready high: order visible one cycle, popped next edge.

## Structure
- Package trade_pkg: order record typedef (side, stock_id, price, qty), SIDE_BUY/SIDE_SELL constants, PRICE_W = 14, QTY_W = 8, MONEY_W = 32.
- Sub-module order_fifo: synchronous FIFO, FIFO_DEPTH entries of the order record, full/empty from registered count, with its own synchronous active-low reset.

## Test plan
- Buy stock 0 @10900 -> order {buy, 0, 10900, 10}, cash 91000; buy stock 0 @10900 six cycles later -> rejected (cash 91000 < 109000), drop_count 1.
- Buys stock 1 @750 at cycles 0, 5, 10 -> lots 3, cash 177500; buy at cycle 15 -> rejected, drop_count 1.
- Then sell stock 1 @800 -> order {sell, 1, 800, 30}, cash 201500, realized_pnl 1500, lots[1] 0.
- Buy stock 2 @1250 at edge N; buy at N+4 -> dropped; buy at N+5 -> accepted, lots[2] 2.
- order_ready low; buys stocks 0–3 @100 on consecutive cycles, then stock 0 @100 at +5 -> queue full, 5th rejected; ready high -> four orders stock 0,1,2,3 on consecutive cycles, then order_valid 0.
- buy_signal and sell_signal both high -> drop_count +1, ledger unchanged; rst low with 3 queued orders -> order_valid 0, cash 200000 next cycle.
